// File: rtl/wb_pkg.sv
// Shared types for the register-file write-back buffer.
package wb_pkg;

    localparam int AW = 5;
    localparam int DW = 32;

    typedef struct packed {
        logic [AW-1:0] w;
        logic [DW-1:0] wd;
    } wb_entry_t;

    localparam logic [AW-1:0] ZERO_REG = '0;

endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer of write-back entries: up to two ordered pushes and one pop per cycle.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rs_n,
    input  logic             push0,
    input  wb_entry_t        entry0,
    input  logic             push1,
    input  wb_entry_t        entry1,
    input  logic             pop,
    output logic [CW-1:0]    count,
    output wb_entry_t        head,
    output wb_entry_t        entries [DEPTH],
    output logic [DEPTH-1:0] valid
);

    wb_entry_t       mem [DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [PW-1:0]   wptr1;

    // The second push lands after the first one when both are present.
    assign wptr1 = wptr + PW'(push0);

    always_ff @(posedge clk or negedge rs_n) begin
        if (!rs_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (pop) begin
                valid[rptr] <= 1'b0;
                rptr        <= rptr + PW'(1);
            end
            if (push0) valid[wptr]  <= 1'b1;
            if (push1) valid[wptr1] <= 1'b1;
            wptr  <= wptr + PW'(push0) + PW'(push1);
            count <= count + CW'(push0) + CW'(push1) - CW'(pop);
        end
    end

    // Payload storage carries no reset; the valid bits decide occupancy.
    always_ff @(posedge clk) begin
        if (push0) mem[wptr]  <= entry0;
        if (push1) mem[wptr1] <= entry1;
    end

    assign head    = mem[rptr];
    assign entries = mem;

endmodule

// File: rtl/regfile_writeback.sv
// Write-back buffer: arbitrates ALU/memory requests into an in-order FIFO and drains it into the register file.
module regfile_writeback #(
    parameter int DEPTH = 4,
    parameter int AW    = wb_pkg::AW,
    parameter int DW    = wb_pkg::DW,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rs_n,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_w,
    input  logic [DW-1:0] alu_wd,
    output logic          alu_ready,
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_w,
    input  logic [DW-1:0] mem_wd,
    output logic          mem_ready,
    input  logic          rf_busy,
    output logic          wr_en,
    output logic [AW-1:0] wr_w,
    output logic [DW-1:0] wr_wd,
    input  logic [AW-1:0] ra,
    input  logic [AW-1:0] rb,
    output logic          ra_pend,
    output logic          rb_pend,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    wb_pkg::wb_entry_t alu_entry;
    wb_pkg::wb_entry_t mem_entry;
    wb_pkg::wb_entry_t entry0;
    wb_pkg::wb_entry_t head;
    wb_pkg::wb_entry_t entries [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [CW-1:0]     free;
    logic              alu_push;
    logic              mem_push;
    logic              push0;
    logic              push1;
    logic              ra_hit;
    logic              rb_hit;

    // Free space comes from registered occupancy only, so a pop never frees a slot in the same cycle.
    assign free      = CW'(DEPTH) - count;
    assign mem_ready = (free >= CW'(1));
    assign alu_ready = (free >= CW'(2)) | ((free == CW'(1)) & ~mem_valid);

    assign alu_entry = '{w: alu_w, wd: alu_wd};
    assign mem_entry = '{w: mem_w, wd: mem_wd};

    // Writes to the zero register complete the handshake but are dropped here.
    assign mem_push = mem_valid & mem_ready & (mem_w != wb_pkg::ZERO_REG);
    assign alu_push = alu_valid & alu_ready & (alu_w != wb_pkg::ZERO_REG);
    assign push0    = mem_push | alu_push;
    assign entry0   = mem_push ? mem_entry : alu_entry;
    assign push1    = mem_push & alu_push;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rs_n    (rs_n),
        .push0   (push0),
        .entry0  (entry0),
        .push1   (push1),
        .entry1  (alu_entry),
        .pop     (wr_en),
        .count   (count),
        .head    (head),
        .entries (entries),
        .valid   (valid)
    );

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign wr_en = ~empty & ~rf_busy;
    assign wr_w  = empty ? '0 : head.w;
    assign wr_wd = empty ? '0 : head.wd;

    always_comb begin
        ra_hit = 1'b0;
        rb_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && entries[i].w == ra) ra_hit = 1'b1;
            if (valid[i] && entries[i].w == rb) rb_hit = 1'b1;
        end
    end

    assign ra_pend = ra_hit & (ra != wb_pkg::ZERO_REG);
    assign rb_pend = rb_hit & (rb != wb_pkg::ZERO_REG);

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback (DEPTH=4, AW=5, DW=32).
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        rs_n;
    logic        alu_valid;
    logic [4:0]  alu_w;
    logic [31:0] alu_wd;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_w;
    logic [31:0] mem_wd;
    logic        mem_ready;
    logic        rf_busy;
    logic        wr_en;
    logic [4:0]  wr_w;
    logic [31:0] wr_wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        ra_pend;
    logic        rb_pend;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    int checks = 0;
    int errors = 0;

    regfile_writeback #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk       (clk),
        .rs_n      (rs_n),
        .alu_valid (alu_valid),
        .alu_w     (alu_w),
        .alu_wd    (alu_wd),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_w     (mem_w),
        .mem_wd    (mem_wd),
        .mem_ready (mem_ready),
        .rf_busy   (rf_busy),
        .wr_en     (wr_en),
        .wr_w      (wr_w),
        .wr_wd     (wr_wd),
        .ra        (ra),
        .rb        (rb),
        .ra_pend   (ra_pend),
        .rb_pend   (rb_pend),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_req(input logic v, input logic [4:0] w, input logic [31:0] wd);
        alu_valid = v;
        alu_w     = w;
        alu_wd    = wd;
    endtask

    task automatic mem_req(input logic v, input logic [4:0] w, input logic [31:0] wd);
        mem_valid = v;
        mem_w     = w;
        mem_wd    = wd;
    endtask

    initial begin
        rs_n = 1'b0;
        alu_req(1'b0, 5'd0, 32'd0);
        mem_req(1'b0, 5'd0, 32'd0);
        rf_busy = 1'b0;
        ra = 5'd0;
        rb = 5'd0;
        #3;
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_wr_w", wr_w, 5'd0);
        chk("rst_wr_wd", wr_wd, 32'd0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_count", count, 3'd0);
        chk("rst_alu_ready", alu_ready, 1'b1);
        chk("rst_mem_ready", mem_ready, 1'b1);
        chk("rst_ra_pend", ra_pend, 1'b0);
        chk("rst_rb_pend", rb_pend, 1'b0);
        #9 rs_n = 1'b1;
        tick();

        // Single ALU write
        alu_req(1'b1, 5'd3, 32'hDEADBEEF);
        #1 chk("t1_alu_ready", alu_ready, 1'b1);
        tick();
        alu_req(1'b0, 5'd0, 32'd0);
        #1;
        chk("t1_wr_en", wr_en, 1'b1);
        chk("t1_wr_w", wr_w, 5'd3);
        chk("t1_wr_wd", wr_wd, 32'hDEADBEEF);
        chk("t1_count", count, 3'd1);
        tick();
        chk("t1_empty", empty, 1'b1);
        chk("t1_idle_wr_en", wr_en, 1'b0);

        // Dual accept: memory entry is older
        mem_req(1'b1, 5'd5, 32'd1);
        alu_req(1'b1, 5'd6, 32'd2);
        #1;
        chk("t2_mem_ready", mem_ready, 1'b1);
        chk("t2_alu_ready", alu_ready, 1'b1);
        tick();
        mem_req(1'b0, 5'd0, 32'd0);
        alu_req(1'b0, 5'd0, 32'd0);
        #1;
        chk("t2_count", count, 3'd2);
        chk("t2_first_w", wr_w, 5'd5);
        chk("t2_first_wd", wr_wd, 32'd1);
        tick();
        chk("t2_second_w", wr_w, 5'd6);
        chk("t2_second_wd", wr_wd, 32'd2);
        chk("t2_count1", count, 3'd1);
        tick();
        chk("t2_empty", empty, 1'b1);

        // Last-slot priority and full behaviour
        rf_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu_req(1'b1, 5'(8 + i), 32'(80 + i));
            tick();
        end
        alu_req(1'b0, 5'd0, 32'd0);
        #1 chk("t3_count3", count, 3'd3);
        mem_req(1'b1, 5'd11, 32'd110);
        alu_req(1'b1, 5'd12, 32'd120);
        #1;
        chk("t3_mem_ready", mem_ready, 1'b1);
        chk("t3_alu_ready", alu_ready, 1'b0);
        tick();
        mem_req(1'b0, 5'd0, 32'd0);
        alu_req(1'b0, 5'd0, 32'd0);
        #1;
        chk("t3_full", full, 1'b1);
        chk("t3_count4", count, 3'd4);
        chk("t3_full_alu_ready", alu_ready, 1'b0);
        chk("t3_full_mem_ready", mem_ready, 1'b0);
        chk("t3_busy_wr_en", wr_en, 1'b0);
        rf_busy = 1'b0;
        alu_req(1'b1, 5'd13, 32'd130);
        #1;
        chk("t3_pop_wr_en", wr_en, 1'b1);
        chk("t3_pop_w", wr_w, 5'd8);
        chk("t3_pop_alu_ready", alu_ready, 1'b0);
        chk("t3_pop_mem_ready", mem_ready, 1'b0);
        tick();
        chk("t3_after_pop_count", count, 3'd3);
        chk("t3_after_pop_alu_ready", alu_ready, 1'b1);
        chk("t3_w9", wr_w, 5'd9);
        tick();
        alu_req(1'b0, 5'd0, 32'd0);
        #1;
        chk("t3_pushpop_count", count, 3'd3);
        chk("t3_w10", wr_w, 5'd10);
        tick();
        chk("t3_w11", wr_w, 5'd11);
        chk("t3_wd11", wr_wd, 32'd110);
        tick();
        chk("t3_w13", wr_w, 5'd13);
        chk("t3_wd13", wr_wd, 32'd130);
        tick();
        chk("t3_empty", empty, 1'b1);

        // Back-pressure: four writes held for five cycles
        rf_busy = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) alu_req(1'b1, 5'(i), 32'(100 + i));
            else        alu_req(1'b0, 5'd0, 32'd0);
            #1 chk("t4_busy_wr_en", wr_en, 1'b0);
            tick();
        end
        chk("t4_full", full, 1'b1);
        chk("t4_head_stable", wr_w, 5'd1);
        rf_busy = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("t4_drain_en", wr_en, 1'b1);
            chk("t4_drain_w", wr_w, 5'(i));
            chk("t4_drain_wd", wr_wd, 32'(100 + i));
            tick();
        end
        chk("t4_empty", empty, 1'b1);

        // Zero register and hazards
        alu_req(1'b1, 5'd0, 32'h55);
        #1 chk("t5_zero_ready", alu_ready, 1'b1);
        tick();
        alu_req(1'b0, 5'd0, 32'd0);
        #1;
        chk("t5_zero_count", count, 3'd0);
        chk("t5_zero_wr_en", wr_en, 1'b0);
        rf_busy = 1'b1;
        alu_req(1'b1, 5'd7, 32'h77);
        tick();
        alu_req(1'b0, 5'd0, 32'd0);
        ra = 5'd7;
        rb = 5'd0;
        #1;
        chk("t5_ra_pend", ra_pend, 1'b1);
        chk("t5_rb_pend", rb_pend, 1'b0);
        rb = 5'd6;
        #1 chk("t5_rb_other", rb_pend, 1'b0);
        rf_busy = 1'b0;
        #1;
        chk("t5_head_wr_en", wr_en, 1'b1);
        chk("t5_head_pend", ra_pend, 1'b1);
        tick();
        chk("t5_drained_pend", ra_pend, 1'b0);
        ra = 5'd0;
        rb = 5'd0;

        // Asynchronous reset mid-cycle
        rf_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu_req(1'b1, 5'(20 + i), 32'(200 + i));
            tick();
        end
        alu_req(1'b0, 5'd0, 32'd0);
        ra = 5'd21;
        rf_busy = 1'b0;
        #1;
        chk("t6_pre_count", count, 3'd3);
        chk("t6_pre_wr_en", wr_en, 1'b1);
        chk("t6_pre_pend", ra_pend, 1'b1);
        rs_n = 1'b0;
        #1;
        chk("t6_rst_wr_en", wr_en, 1'b0);
        chk("t6_rst_count", count, 3'd0);
        chk("t6_rst_empty", empty, 1'b1);
        chk("t6_rst_wr_w", wr_w, 5'd0);
        chk("t6_rst_pend", ra_pend, 1'b0);
        #1 rs_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_post_wr_en", wr_en, 1'b0);
            chk("t6_post_empty", empty, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-back buffer between the execute/memory stages and the register file write port. Accepts register-write requests from two producers (single-cycle ALU, multi-cycle memory/multiply unit) over valid/ready handshakes. Queues them in a small in-order FIFO and drains them one per cycle into the register file's `w`/`wd`/`en` write port. Reports pending-write hazards for the two register-file read addresses so the issue logic can stall.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `AW`, 5: register address width.
- `DW`, 32: data width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rs_n`  in  1  reset, asynchronous, active-low.
- `alu_valid`  in  1  ALU request valid.
- `alu_w`  in  AW  ALU destination register.
- `alu_wd`  in  DW  ALU result.
- `alu_ready`  out  1  ALU request accepted this cycle if valid.
- `mem_valid`  in  1  memory/multiply request valid.
- `mem_w`  in  AW  memory destination register.
- `mem_wd`  in  DW  memory result.
- `mem_ready`  out  1  memory request accepted this cycle if valid.
- `rf_busy`  in  1  register file cannot take a write this cycle.
- `wr_en`  out  1  register-file write enable.
- `wr_w`  out  AW  register-file write address.
- `wr_wd`  out  DW  register-file write data.
- `ra`, `rb`  in  AW  register-file read addresses under issue.
- `ra_pend`, `rb_pend`  out  1  queued write targets `ra` / `rb`.
- `count`  out  $clog2(DEPTH)+1  occupied entries.
- `full`, `empty`  out  1  `count==DEPTH` / `count==0`.

## Operation
- Transfer happens on a rising edge where both `valid` and `ready` are high.
- `free = DEPTH - count`, taken from registered state only. A pop in the same cycle does not raise `free`.
- `mem_ready = (free >= 1)`.
- `alu_ready = (free >= 2) | ((free == 1) & ~mem_valid)`. Memory has priority for the last slot.
- If both producers transfer in one cycle, the memory entry is enqueued first (older), then the ALU entry.
- A request with destination 0 completes the handshake but is not enqueued.
- Head presentation is combinational:
  - `wr_en = ~empty & ~rf_busy`
  - `wr_w`, `wr_wd` = head entry
  - When `empty`, `wr_w` and `wr_wd` are 0.
- Pop on the edge where `wr_en` is high. Push and pop in the same cycle are allowed; `count` changes by pushes minus pop.
- Hazard flags:
  - `ra_pend = (ra != 0) & any occupied entry has w == ra`.
  - `rb_pend` is the same for `rb`.
  - The head entry counts as pending even in the cycle it is being written.
- Ordering: entries drain strictly in enqueue order. Two queued writes to the same register both reach the register file, oldest first.
- Pointers wrap modulo `DEPTH`. `count` saturates by construction and never exceeds `DEPTH`.

## Timing
- Reset (`rs_n` low, asynchronous): pointers and `count` go to 0, all entries are discarded, and the outputs take these values immediately, without waiting for a clock edge:
  - `wr_en`=0, `wr_w`=0, `wr_wd`=0
  - `empty`=1, `full`=0
  - `ra_pend`=0, `rb_pend`=0
  - `alu_ready`=1, `mem_ready`=1
- A reset mid-drain drops all queued writes.
- Latency: request accepted at edge N appears on the write port during cycle N→N+1 (if it is the head and `rf_busy` is low) and is written at edge N+1.
- Throughput: one write per cycle to the register file. Up to two accepts per cycle.
- `rf_busy` high holds the head stable and keeps `wr_en` low. Accepts continue until full.
- Full state: both readies low. Neither rises in the cycle of a pop; they rise in the following cycle.

## Structure
- Shared package `wb_pkg`:
  - `DW` and `AW` defaults.
  - Typedef `wb_entry_t` = {w[AW-1:0], wd[DW-1:0]}.
  - Constant `ZERO_REG` = 0.
- Sub-module `wb_fifo`:
  - Dual-push (ordered), single-pop circular buffer of `wb_entry_t`.
  - Exposes `count` and the full entry array plus valid bits, used by the hazard compare.
- Top level holds the handshake arbitration, the zero-register filter and the two address comparators.

## Test plan
- Single ALU write: `alu_w`=3, `alu_wd`=32'hDEADBEEF accepted at edge 1 → `wr_en`=1, `wr_w`=3, `wr_wd`=DEADBEEF in cycle 1–2; `empty`=1 after edge 2.
- Dual accept: both valid, `mem_w`=5/`wd`=1, `alu_w`=6/`wd`=2, FIFO empty → `count`=2; write order is reg 5 then reg 6.
- Last-slot priority: `count`=3 (`DEPTH`=4), both valid → `mem_ready`=1, `alu_ready`=0; `full`=1 next cycle; both readies 0 while full.
- Back-pressure: `rf_busy`=1 for 5 cycles with 4 ALU writes → `wr_en`=0 throughout and `full`=1. After release, 4 consecutive writes are issued in order, one per cycle.
- Zero register and hazards:
  - `alu_w`=0 accepted → `count` unchanged, no write.
  - With reg 7 queued, `ra`=7 → `ra_pend`=1; `rb`=0 → `rb_pend`=0.
  - After reg 7 drains → `ra_pend`=0.
- Async reset: assert `rs_n`=0 mid-cycle with 3 entries queued → `wr_en`=0, `count`=0, `empty`=1 before the next edge. No queued write appears after `rs_n` returns high.
